bv_lshr_inv_solver: RTL and testbench



---
 rtl/bv_lshr_inv_solver.sv | 220 ++++++++++++++++++++++
 tb/tb_bv_lshr_inv_solver.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bv_lshr_inv_solver.sv
`default_nettype none
// ============================================================================
// Module   : bv_lshr_inv_solver
// Purpose  : Sequential invertibility solver for logical shift right.
//            Given s and t, finds a witness x with
//              pos=0 : (x >> s) == t
//              pos=1 : (s >> x) == t   (minimal shift amount returned)
//            or reports that no such x exists. Valid/ready request/response.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : request valid            in_ready : high only when idle
//   in_pos      : unknown operand position in_s/in_t: known operand / target
//   out_valid   : result valid, held until out_ready
//   out_sat     : 1 = witness found        out_x    : witness (0 if unsat)
//   busy        : request in flight (searching or holding a result)
// Optional build macro
//   BVINV_STATS_EN : adds saturating 16-bit handshake counters
//                    stat_sat / stat_unsat.
// ============================================================================
module bv_lshr_inv_solver #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_pos,
  input  logic [WIDTH-1:0] in_s,
  input  logic [WIDTH-1:0] in_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sat,
  output logic [WIDTH-1:0] out_x,
  output logic             busy
`ifdef BVINV_STATS_EN
  ,
  output logic [15:0]      stat_sat,
  output logic [15:0]      stat_unsat
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Candidate index that stands for "any shift amount >= WIDTH".
  localparam logic [CW-1:0] K_LAST = CW'(WIDTH);

  state_t           state_q, state_d;
  logic             pos_q, pos_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [CW-1:0]    k_q, k_d;
  // Evaluation pipeline register: the shifter result for candidate evk_q is
  // registered, and compared against t in the following cycle. This keeps the
  // barrel shifter and the comparator in separate cycles.
  logic [WIDTH-1:0] ev_q, ev_d;
  logic [CW-1:0]    evk_q, evk_d;
  logic             ev_vld_q, ev_vld_d;
  logic             sat_q, sat_d;
  logic [WIDTH-1:0] x_q, x_d;

  logic [WIDTH-1:0] w_eval;
  logic [WIDTH-1:0] w_cmp;
  logic             w_hit;
  logic             w_issue;

  // Shifter stage. pos=0 builds the single candidate t << s; pos=1 evaluates
  // s >> k, with k == WIDTH meaning a full shift-out.
  always_comb begin
    w_eval = '0;
    if (pos_q) begin
      if (k_q != K_LAST) begin
        w_eval = s_q >> k_q;
      end
    end else begin
      if (int'(s_q) < WIDTH) begin
        w_eval = t_q << s_q;
      end
    end
  end

  // Compare stage. For pos=0 the candidate is verified by shifting it back.
  assign w_cmp   = pos_q ? ev_q : (ev_q >> s_q);
  assign w_hit   = (w_cmp == t_q);
  assign w_issue = pos_q ? (k_q <= K_LAST) : (k_q == '0);

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    s_d      = s_q;
    t_d      = t_q;
    k_d      = k_q;
    ev_d     = ev_q;
    evk_d    = evk_q;
    ev_vld_d = 1'b0;
    sat_d    = sat_q;
    x_d      = x_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_SEARCH;
          pos_d   = in_pos;
          s_d     = in_s;
          t_d     = in_t;
          k_d     = '0;
          sat_d   = 1'b0;
          x_d     = '0;
        end
      end

      ST_SEARCH: begin
        if (w_issue) begin
          ev_d     = w_eval;
          evk_d    = k_q;
          ev_vld_d = 1'b1;
          k_d      = k_q + CW'(1);
        end
        if (ev_vld_q) begin
          if (pos_q) begin
            if (w_hit) begin
              state_d = ST_DONE;
              sat_d   = 1'b1;
              x_d     = WIDTH'(evk_q);
            end else if (evk_q == K_LAST) begin
              state_d = ST_DONE;
              sat_d   = 1'b0;
              x_d     = '0;
            end
          end else begin
            state_d = ST_DONE;
            sat_d   = w_hit;
            x_d     = w_hit ? ev_q : '0;
          end
          // A candidate issued in the deciding cycle is speculative; drop it.
          if (state_d == ST_DONE) begin
            ev_vld_d = 1'b0;
          end
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          sat_d   = 1'b0;
          x_d     = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pos_q    <= 1'b0;
      s_q      <= '0;
      t_q      <= '0;
      k_q      <= '0;
      ev_q     <= '0;
      evk_q    <= '0;
      ev_vld_q <= 1'b0;
      sat_q    <= 1'b0;
      x_q      <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      s_q      <= s_d;
      t_q      <= t_d;
      k_q      <= k_d;
      ev_q     <= ev_d;
      evk_q    <= evk_d;
      ev_vld_q <= ev_vld_d;
      sat_q    <= sat_d;
      x_q      <= x_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_sat   = sat_q;
  assign out_x     = x_q;

`ifdef BVINV_STATS_EN
  logic [15:0] stat_sat_q;
  logic [15:0] stat_unsat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_sat_q   <= '0;
      stat_unsat_q <= '0;
    end else if ((state_q == ST_DONE) && out_ready) begin
      if (sat_q) begin
        if (stat_sat_q != 16'hFFFF) begin
          stat_sat_q <= stat_sat_q + 16'd1;
        end
      end else begin
        if (stat_unsat_q != 16'hFFFF) begin
          stat_unsat_q <= stat_unsat_q + 16'd1;
        end
      end
    end
  end

  assign stat_sat   = stat_sat_q;
  assign stat_unsat = stat_unsat_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bv_lshr_inv_solver.sv
`default_nettype none
// ============================================================================
// Module   : tb_bv_lshr_inv_solver
// Purpose  : Self-checking bench for bv_lshr_inv_solver (WIDTH=4). A
//            request-level reference model predicts result and latency;
//            directed vectors carry hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bv_lshr_inv_solver;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_pos;
  logic [W-1:0] in_s;
  logic [W-1:0] in_t;
  logic         out_valid;
  logic         out_ready;
  logic         out_sat;
  logic [W-1:0] out_x;
  logic         busy;
`ifdef BVINV_STATS_EN
  logic [15:0]  stat_sat;
  logic [15:0]  stat_unsat;
`endif

  bv_lshr_inv_solver #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pos    (in_pos),
    .in_s      (in_s),
    .in_t      (in_t),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sat   (out_sat),
    .out_x     (out_x),
    .busy      (busy)
`ifdef BVINV_STATS_EN
    ,
    .stat_sat  (stat_sat),
    .stat_unsat(stat_unsat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: answers a request straight from the shift definitions.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic         sat;
    logic [W-1:0] x;
    logic [31:0]  lat;
  } res_t;

  function automatic res_t model(input logic pos, input logic [W-1:0] s, input logic [W-1:0] t);
    res_t         r;
    logic [W-1:0] cand;
    logic [W-1:0] ev;
    r.sat = 1'b0;
    r.x   = '0;
    if (!pos) begin
      cand = t << s;
      if (int'(s) >= W) cand = '0;
      r.lat = 32'd2;
      if ((cand >> s) == t) begin
        r.sat = 1'b1;
        r.x   = cand;
      end
    end else begin
      r.lat = 32'(2 + W);
      for (int k = 0; k <= W; k++) begin
        ev = (k == W) ? '0 : (s >> k);
        if (!r.sat && ev == t) begin
          r.sat = 1'b1;
          r.x   = W'(k);
          r.lat = 32'(2 + k);
        end
      end
    end
    return r;
  endfunction

  // Transaction-level tracking of what the solver must be showing.
  int   cyc;
  int   m_acc;
  logic m_busy;
  logic m_valid;
  res_t m_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc     <= 0;
      m_acc   <= 0;
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_res   <= '0;
    end else begin
      cyc <= cyc + 1;
      if (!m_busy) begin
        if (in_valid) begin
          m_busy <= 1'b1;
          m_acc  <= cyc + 1;
          m_res  <= model(in_pos, in_s, in_t);
        end
      end else if (m_valid) begin
        if (out_ready) begin
          m_busy  <= 1'b0;
          m_valid <= 1'b0;
        end
      end else if (cyc + 1 == m_acc + int'(m_res.lat)) begin
        m_valid <= 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    chk("in_ready", in_ready, !m_busy);
    chk("busy", busy, m_busy);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_sat", out_sat, m_res.sat);
      chk("out_x", out_x, m_res.x);
    end
    if (rst) begin
      chk("rst_out_sat", out_sat, 1'b0);
      chk("rst_out_x", out_x, '0);
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  // Called at the negedge following the accept edge.
  task automatic wait_res(input string name, input logic esat, input logic [W-1:0] ex, input int elat);
    int lat = 0;
    bit got = 0;
    while (!got && lat < 40) begin
      if (out_valid) got = 1;
      else begin
        @(posedge clk);
        @(negedge clk);
        lat++;
      end
    end
    chk({name, "_seen"}, got, 1'b1);
    chk({name, "_sat"}, out_sat, esat);
    chk({name, "_x"}, out_x, ex);
    chk({name, "_lat"}, lat, elat);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic issue(input logic pos, input logic [W-1:0] s, input logic [W-1:0] t);
    @(negedge clk);
    in_valid = 1'b1;
    in_pos   = pos;
    in_s     = s;
    in_t     = t;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_s     = ~s;
    in_t     = ~t;
  endtask

  task automatic run_req(input string name, input logic pos, input logic [W-1:0] s,
                         input logic [W-1:0] t, input logic esat, input logic [W-1:0] ex,
                         input int elat);
    issue(pos, s, t);
    wait_res(name, esat, ex, elat);
    consume();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pos    = 1'b0;
    in_s      = '0;
    in_t      = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    rst = 1'b0;

    run_req("p0_s1_t5",   1'b0, 4'd1, 4'b0101, 1'b1, 4'b1010, 2);
    run_req("p0_s1_t8",   1'b0, 4'd1, 4'b1000, 1'b0, 4'b0000, 2);
    run_req("p0_s6_t0",   1'b0, 4'd6, 4'b0000, 1'b1, 4'b0000, 2);
    run_req("p0_s4_t1",   1'b0, 4'd4, 4'b0001, 1'b0, 4'b0000, 2);
    run_req("p0_s0_t9",   1'b0, 4'd0, 4'b1001, 1'b1, 4'b1001, 2);
    run_req("p1_c_3",     1'b1, 4'b1100, 4'b0011, 1'b1, 4'd2, 4);
    run_req("p1_6_0",     1'b1, 4'b0110, 4'b0000, 1'b1, 4'd3, 5);
    run_req("p1_c_5",     1'b1, 4'b1100, 4'b0101, 1'b0, 4'd0, 6);
    run_req("p1_b_b",     1'b1, 4'b1011, 4'b1011, 1'b1, 4'd0, 2);
    run_req("p1_f_0",     1'b1, 4'b1111, 4'b0000, 1'b1, 4'd4, 6);
    run_req("p1_1_0",     1'b1, 4'b0001, 4'b0000, 1'b1, 4'd1, 3);

    // Backpressure: result held while a competing request waits.
    issue(1'b1, 4'b1100, 4'b0011);
    wait_res("bp", 1'b1, 4'd2, 4);
    in_valid = 1'b1;
    in_pos   = 1'b0;
    in_s     = 4'd1;
    in_t     = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_x", out_x, 4'd2);
      chk("bp_hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_ready_after", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_res("bp_next", 1'b1, 4'b1010, 2);
    consume();

    // Reset in the middle of an unsat pos=1 search.
    issue(1'b1, 4'b1100, 4'b0101);
    @(posedge clk);
    @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_out_x", out_x, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_req("post_rst", 1'b0, 4'd2, 4'b0011, 1'b1, 4'b1100, 2);
`ifdef BVINV_STATS_EN
    chk("stat_sat", stat_sat, 16'd1);
    chk("stat_unsat", stat_unsat, 16'd0);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
